iec_sd_arbiter: RTL and testbench
=================================

IEC_SD_ARBITER -- requirements
Module: iec_sd_arbiter

Interface
REQ-001 Parameter: DRIVES, default 2, number of drive channels; clamped to 1..4 as NDR; N = NDR-1.
REQ-002 Parameter: TMO_BITS, default 20, width of the request-timeout counter.
REQ-003 clk_sys  in  1  Sole clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  Reset, asynchronous assert, active-low.
REQ-005 drv_lba  in  32 x NDR  Per-drive block address.
REQ-006 drv_blk_cnt  in  6 x NDR  Per-drive block count minus one.
REQ-007 drv_rd  in  NDR  Per-drive read request, level, held until its ack.
REQ-008 drv_wr  in  NDR  Per-drive write request, level, held until its ack.
REQ-009 drv_ack  out  NDR  Per-drive ack, one-hot or zero.
REQ-010 drv_buff_din  in  8 x NDR  Per-drive write data toward host.
REQ-011 drv_buff_wr  out  NDR  Per-drive buffer write strobe, one-hot or zero.
REQ-012 sd_lba  out  32  Host block address, latched at grant.
REQ-013 sd_blk_cnt  out  6  Host block count, latched at grant.
REQ-014 sd_rd / sd_wr  out  1 each  Host request strobes, mutually exclusive.
REQ-015 sd_ack  in  1  Host acknowledge, high for the whole transfer.
REQ-016 sd_buff_wr  in  1  Host buffer write strobe.
REQ-017 sd_buff_din  out  8  Write data routed from the owning drive.
REQ-018 owner  out  2  Index of the granted drive.
REQ-019 busy  out  1  High outside IDLE.
REQ-020 tmo_err  out  1  One-cycle pulse on request timeout.

Function
REQ-021 FSM states are IDLE, REQ, XFER and DONE.
REQ-022 IDLE: arbitrate when any drv_rd|drv_wr is high; otherwise remain in IDLE.
REQ-023 Arbitration is round-robin: the search starts at (last_owner+1) mod NDR, and the first drive found with a pending request wins.
REQ-024 A drive with both drv_wr and drv_rd high is granted as a write.
REQ-025 On grant: latch owner, sd_lba, sd_blk_cnt and direction; next cycle enter REQ with sd_rd or sd_wr high; grant latency is 1 clock from request to strobe.
REQ-026 REQ: hold the strobe.
REQ-027 REQ, sd_ack rises: enter XFER and drop the strobe in the same cycle.
REQ-028 REQ, owner's request falls before sd_ack rises: abort, drop the strobe, return to IDLE, do not advance last_owner.
REQ-029 REQ: a TMO_BITS counter increments each cycle and is cleared on entry.
REQ-030 REQ, counter saturates (2^TMO_BITS-1): drop the strobe, pulse tmo_err, advance last_owner to owner, return to IDLE.
REQ-031 XFER: drv_ack[owner] = 1.
REQ-032 XFER: drv_buff_wr[owner] = sd_buff_wr combinationally.
REQ-033 XFER: sd_buff_din = drv_buff_din[owner] combinationally.
REQ-034 XFER: all other drv_ack and drv_buff_wr bits are 0.
REQ-035 XFER, sd_ack falls: enter DONE.
REQ-036 DONE: lasts exactly one cycle with drv_ack = 0; set last_owner = owner; return to IDLE.
REQ-037 Back-to-back requests are re-arbitrated in the IDLE cycle after DONE, so there are at least 2 idle-strobe cycles between transfers.
REQ-038 Requests from non-owner drives during a transfer stay pending; they are never dropped or latched early.
REQ-039 sd_lba and sd_blk_cnt are stable from grant through DONE regardless of drv_lba changes.
REQ-040 sd_ack high in IDLE is ignored; no ack is forwarded.
REQ-041 When no transfer is in progress (not XFER): sd_buff_din = 0 and drv_buff_wr = 0.
REQ-042 NDR=1: the arbiter degenerates to a pass-through with the same FSM timing; owner = 0.

Reset
REQ-043 reset_n low asynchronously forces the following within the same cycle: IDLE, owner=0, last_owner=N (so drive 0 wins first), sd_rd=sd_wr=0, sd_lba=0, sd_blk_cnt=0, drv_ack=0, drv_buff_wr=0, tmo_err=0, busy=0, counter=0.
REQ-044 Reset mid-transfer abandons the transfer; after release the FSM re-arbitrates from pending levels.

Verification
REQ-045 DRIVES=2, drv_rd=2'b01, drv_lba[0]=0x100 -> sd_rd high next clock, sd_lba=0x100, owner=0; sd_ack pulse 10 clocks -> drv_ack[0] high for those 10 clocks only.
REQ-046 drv_rd=2'b11 held continuously after reset -> grant order 0,1,0,1 over four transfers.
REQ-047 drv_rd[0] and drv_wr[0] both high -> sd_wr asserted, sd_rd stays 0; sd_buff_wr strobes in XFER appear only on drv_buff_wr[0]; sd_buff_din tracks drv_buff_din[0].
REQ-048 TMO_BITS=4, request with sd_ack never asserted -> sd_wr/sd_rd drop after 15 REQ cycles, tmo_err pulses once, the next grant goes to the other drive.
REQ-049 reset_n low during XFER -> all outputs zero immediately; after release with drv_rd[1] still high -> drive 1 granted.
REQ-050 drv_rd[0] withdrawn in REQ before sd_ack -> strobe drops next clock, return to IDLE, last_owner unchanged.

Source files
------------

// File: rtl/iec_sd_arbiter.sv
// Round-robin arbiter that multiplexes up to four drive channels onto a single SD host port.
// A grant latches the request, strobes the host, then routes ack and write data until the host completes.
module iec_sd_arbiter #(
    parameter  int DRIVES   = 2,
    parameter  int TMO_BITS = 20,
    localparam int NDR      = (DRIVES < 1) ? 1 : ((DRIVES > 4) ? 4 : DRIVES)
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [NDR*32-1:0] drv_lba,
    input  logic [NDR*6-1:0]  drv_blk_cnt,
    input  logic [NDR-1:0]    drv_rd,
    input  logic [NDR-1:0]    drv_wr,
    output logic [NDR-1:0]    drv_ack,
    input  logic [NDR*8-1:0]  drv_buff_din,
    output logic [NDR-1:0]    drv_buff_wr,
    output logic [31:0]       sd_lba,
    output logic [5:0]        sd_blk_cnt,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    input  logic              sd_buff_wr,
    output logic [7:0]        sd_buff_din,
    output logic [1:0]        owner,
    output logic              busy,
    output logic              tmo_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_DONE
    } state_e;

    localparam logic [1:0] LAST_RST = 2'(NDR - 1);

    state_e              state_q, state_d;
    logic [1:0]          owner_q, owner_d;
    logic [1:0]          last_q, last_d;
    logic [31:0]         lba_q, lba_d;
    logic [5:0]          blk_q, blk_d;
    logic                wr_q, wr_d;
    logic [TMO_BITS-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                tmo_err_q, tmo_err_d;

    // Per-drive inputs padded to four slots so a 2-bit drive index always selects cleanly.
    logic [3:0]  pend_v, wr_v;
    logic [31:0] lba_v [4];
    logic [5:0]  blk_v [4];
    logic [7:0]  din_v [4];

    // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pend_v = '0;
        wr_v   = '0;
        for (int i = 0; i < 4; i++) begin
            lba_v[i] = '0;
            blk_v[i] = '0;
            din_v[i] = '0;
        end
        for (int i = 0; i < NDR; i++) begin
            pend_v[i] = drv_rd[i] | drv_wr[i];
            wr_v[i]   = drv_wr[i];
            lba_v[i]  = drv_lba[i*32 +: 32];
            blk_v[i]  = drv_blk_cnt[i*6 +: 6];
            din_v[i]  = drv_buff_din[i*8 +: 8];
        end
    end

    function automatic logic [1:0] rr_pick(input logic [1:0] last, input int k);
        int idx;
        idx = (int'(last) + 1 + k) % NDR;
        return idx[1:0];
    endfunction

    // Scan from the farthest candidate back to the nearest so the nearest pending drive wins.
    logic       arb_found;
    logic [1:0] arb_idx;
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = NDR - 1; k >= 0; k--) begin
            if (pend_v[rr_pick(last_q, k)]) begin
                arb_found = 1'b1;
                arb_idx   = rr_pick(last_q, k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        lba_d     = lba_q;
        blk_d     = blk_q;
        wr_d      = wr_q;
        tmo_cnt_d = '0;
        tmo_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    state_d = S_REQ;
                    owner_d = arb_idx;
                    lba_d   = lba_v[arb_idx];
                    blk_d   = blk_v[arb_idx];
                    wr_d    = wr_v[arb_idx];
                end
            end
            S_REQ: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (sd_ack) begin
                    state_d = S_XFER;
                end else if (!pend_v[owner_q]) begin
                    // Withdrawn request: abandon without charging the drive its turn.
                    state_d = S_IDLE;
                end else if (tmo_cnt_d == '1) begin
                    state_d   = S_IDLE;
                    tmo_err_d = 1'b1;
                    last_d    = owner_q;
                end
            end
            S_XFER: begin
                if (!sd_ack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            last_q    <= LAST_RST;
            lba_q     <= '0;
            blk_q     <= '0;
            wr_q      <= 1'b0;
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            lba_q     <= lba_d;
            blk_q     <= blk_d;
            wr_q      <= wr_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    always_comb begin
        drv_ack     = '0;
        drv_buff_wr = '0;
        sd_buff_din = '0;
        if (state_q == S_XFER) begin
            sd_buff_din = din_v[owner_q];
            for (int i = 0; i < NDR; i++) begin
                drv_ack[i]     = (owner_q == 2'(i));
                drv_buff_wr[i] = (owner_q == 2'(i)) & sd_buff_wr;
            end
        end
    end

    assign sd_rd      = (state_q == S_REQ) & ~wr_q;
    assign sd_wr      = (state_q == S_REQ) & wr_q;
    assign sd_lba     = lba_q;
    assign sd_blk_cnt = blk_q;
    assign owner      = owner_q;
    assign busy       = (state_q != S_IDLE);
    assign tmo_err    = tmo_err_q;

endmodule

// File: tb/tb_iec_sd_arbiter.sv
// Self-checking bench for iec_sd_arbiter with two drives and a short timeout counter.
// Expected grants come from a round-robin model over the drive request levels.
module tb_iec_sd_arbiter;

    localparam int TMO = 4;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [63:0] drv_lba;
    logic [11:0] drv_blk_cnt;
    logic [1:0]  drv_rd;
    logic [1:0]  drv_wr;
    logic [1:0]  drv_ack;
    logic [15:0] drv_buff_din;
    logic [1:0]  drv_buff_wr;
    logic [31:0] sd_lba;
    logic [5:0]  sd_blk_cnt;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic [1:0]  owner;
    logic        busy;
    logic        tmo_err;

    int n_cmp;
    int n_err;
    int model_last;

    iec_sd_arbiter #(
        .DRIVES  (2),
        .TMO_BITS(TMO)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .drv_lba     (drv_lba),
        .drv_blk_cnt (drv_blk_cnt),
        .drv_rd      (drv_rd),
        .drv_wr      (drv_wr),
        .drv_ack     (drv_ack),
        .drv_buff_din(drv_buff_din),
        .drv_buff_wr (drv_buff_wr),
        .sd_lba      (sd_lba),
        .sd_blk_cnt  (sd_blk_cnt),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_ack      (sd_ack),
        .sd_buff_wr  (sd_buff_wr),
        .sd_buff_din (sd_buff_din),
        .owner       (owner),
        .busy        (busy),
        .tmo_err     (tmo_err)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        drv_rd       = '0;
        drv_wr       = '0;
        sd_ack       = 1'b0;
        sd_buff_wr   = 1'b0;
        drv_lba      = '0;
        drv_blk_cnt  = '0;
        drv_buff_din = '0;
        tick();
        tick();
        reset_n    = 1'b1;
        model_last = 1;
        tick();
    endtask

    // Waits for the host strobe, then runs one host transfer and checks routing in every XFER cycle.
    task automatic do_transfer(input int exp_owner, input bit exp_wr, input logic [31:0] exp_lba,
                               input logic [5:0] exp_blk, input int ack_delay, input int ack_len,
                               output int lat);
        int          waited;
        logic [63:0] lba_save;
        logic [7:0]  exp_din;
        logic [1:0]  exp_bwr;
        logic [1:0]  exp_ack;
        waited = 0;
        while (!(sd_rd || sd_wr) && waited < 40) begin
            tick();
            waited++;
        end
        lat = waited;
        n_cmp++;
        if (!(sd_rd || sd_wr)) begin
            n_err++;
            $display("FAIL xfer_strobe: no host strobe after %0d cycles, expected one", waited);
            return;
        end
        n_cmp++;
        if ({owner, sd_wr, sd_rd} !== {2'(exp_owner), exp_wr, !exp_wr}) begin
            n_err++;
            $display("FAIL grant: owner=%0d wr=%0b rd=%0b, expected owner=%0d wr=%0b rd=%0b",
                     owner, sd_wr, sd_rd, exp_owner, exp_wr, !exp_wr);
        end
        n_cmp++;
        if ({sd_lba, sd_blk_cnt} !== {exp_lba, exp_blk}) begin
            n_err++;
            $display("FAIL grant_addr: lba=%h cnt=%0d, expected lba=%h cnt=%0d", sd_lba, sd_blk_cnt, exp_lba, exp_blk);
        end
        sd_buff_wr   = 1'b1;
        drv_buff_din = 16'($urandom);
        #1;
        n_cmp++;
        if ({drv_buff_wr, sd_buff_din, drv_ack} !== 12'h000) begin
            n_err++;
            $display("FAIL req_quiet: drv_buff_wr=%b sd_buff_din=%h drv_ack=%b, expected all zero",
                     drv_buff_wr, sd_buff_din, drv_ack);
        end
        sd_buff_wr = 1'b0;
        for (int i = 0; i < ack_delay; i++) tick();
        n_cmp++;
        if ({busy, sd_wr, sd_rd} !== {1'b1, exp_wr, !exp_wr}) begin
            n_err++;
            $display("FAIL strobe_hold: busy=%0b wr=%0b rd=%0b after %0d waits, expected strobe held",
                     busy, sd_wr, sd_rd, ack_delay);
        end
        sd_ack   = 1'b1;
        lba_save = drv_lba;
        exp_ack  = 2'(1 << exp_owner);
        for (int i = 0; i < ack_len; i++) begin
            tick();
            sd_buff_wr   = 1'($urandom);
            drv_buff_din = 16'($urandom);
            drv_lba      = {$urandom, $urandom};
            #1;
            exp_din = drv_buff_din[exp_owner*8 +: 8];
            exp_bwr = sd_buff_wr ? exp_ack : 2'b00;
            n_cmp++;
            if ({drv_ack, drv_buff_wr, sd_buff_din, sd_rd, sd_wr} !== {exp_ack, exp_bwr, exp_din, 2'b00}) begin
                n_err++;
                $display("FAIL xfer_route: cyc %0d ack=%b bwr=%b din=%h rd=%0b wr=%0b, expected ack=%b bwr=%b din=%h no strobe",
                         i, drv_ack, drv_buff_wr, sd_buff_din, sd_rd, sd_wr, exp_ack, exp_bwr, exp_din);
            end
        end
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        tick();
        n_cmp++;
        if ({busy, drv_ack, sd_lba, sd_blk_cnt} !== {1'b1, 2'b00, exp_lba, exp_blk}) begin
            n_err++;
            $display("FAIL done: busy=%0b ack=%b lba=%h cnt=%0d, expected busy=1 ack=00 lba=%h cnt=%0d",
                     busy, drv_ack, sd_lba, sd_blk_cnt, exp_lba, exp_blk);
        end
        drv_lba = lba_save;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, sd_rd, sd_wr, owner, sd_lba, sd_blk_cnt, drv_ack, drv_buff_wr, tmo_err, sd_buff_din} !== '0) begin
            n_err++;
            $display("FAIL reset_state: busy=%0b rd=%0b wr=%0b owner=%0d lba=%h cnt=%0d ack=%b, expected all zero",
                     busy, sd_rd, sd_wr, owner, sd_lba, sd_blk_cnt, drv_ack);
        end
        do_reset();
        sd_ack = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({busy, drv_ack, sd_rd, sd_wr} !== 5'b0) begin
            n_err++;
            $display("FAIL idle_ack_ignored: busy=%0b ack=%b rd=%0b wr=%0b, expected all zero",
                     busy, drv_ack, sd_rd, sd_wr);
        end
        sd_ack = 1'b0;
        tick();
    endtask

    task automatic test_basic_read();
        int lat;
        do_reset();
        drv_lba     = {32'h0, 32'h0000_0100};
        drv_blk_cnt = {6'd0, 6'd7};
        drv_rd      = 2'b01;
        do_transfer(0, 1'b0, 32'h0000_0100, 6'd7, 2, 10, lat);
        n_cmp++;
        if (lat !== 1) begin
            n_err++;
            $display("FAIL grant_latency: strobe after %0d cycles, expected 1", lat);
        end
        drv_rd = 2'b00;
        tick();
        tick();
        n_cmp++;
        if ({busy, sd_rd, sd_wr, drv_ack} !== 5'b0) begin
            n_err++;
            $display("FAIL basic_idle: busy=%0b rd=%0b wr=%0b ack=%b, expected all zero", busy, sd_rd, sd_wr, drv_ack);
        end
    endtask

    task automatic test_round_robin();
        int lat;
        int exp;
        do_reset();
        drv_lba     = {32'hB000_0001, 32'hA000_0000};
        drv_blk_cnt = {6'd9, 6'd3};
        drv_rd      = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp = t % 2;
            do_transfer(exp, 1'b0, (exp == 1) ? 32'hB000_0001 : 32'hA000_0000, (exp == 1) ? 6'd9 : 6'd3,
                        int'($urandom_range(2, 0)), int'($urandom_range(5, 1)), lat);
            n_cmp++;
            if (lat !== ((t == 0) ? 1 : 2)) begin
                n_err++;
                $display("FAIL back_to_back: transfer %0d strobe after %0d cycles, expected %0d", t, lat, (t == 0) ? 1 : 2);
            end
        end
        drv_rd = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_write_priority();
        int lat;
        do_reset();
        drv_lba     = {32'h2222_0000, 32'h1111_0000};
        drv_blk_cnt = {6'd40, 6'd63};
        drv_rd      = 2'b11;
        drv_wr      = 2'b01;
        do_transfer(0, 1'b1, 32'h1111_0000, 6'd63, 1, 6, lat);
        drv_rd = 2'b10;
        drv_wr = 2'b00;
        do_transfer(1, 1'b0, 32'h2222_0000, 6'd40, 0, 3, lat);
        n_cmp++;
        if (lat !== 2) begin
            n_err++;
            $display("FAIL pending_kept: strobe after %0d cycles, expected 2", lat);
        end
        drv_rd = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int cnt;
        int pulses;
        do_reset();
        drv_lba = {32'h0000_0D01, 32'h0000_0D00};
        drv_rd  = 2'b11;
        cnt     = 0;
        pulses  = 0;
        tick();
        while ((sd_rd || sd_wr) && cnt < 40) begin
            cnt++;
            if (tmo_err) pulses++;
            tick();
        end
        n_cmp++;
        if (cnt !== (1 << TMO) - 1) begin
            n_err++;
            $display("FAIL tmo_length: strobe high %0d cycles, expected %0d", cnt, (1 << TMO) - 1);
        end
        if (tmo_err) pulses++;
        n_cmp++;
        if ({tmo_err, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL tmo_pulse: tmo_err=%0b busy=%0b, expected tmo_err=1 busy=0", tmo_err, busy);
        end
        tick();
        if (tmo_err) pulses++;
        n_cmp++;
        if ({sd_rd, owner, sd_lba} !== {1'b1, 2'd1, 32'h0000_0D01}) begin
            n_err++;
            $display("FAIL tmo_next_grant: rd=%0b owner=%0d lba=%h, expected rd=1 owner=1 lba=00000d01",
                     sd_rd, owner, sd_lba);
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_err++;
            $display("FAIL tmo_once: tmo_err seen %0d cycles, expected 1", pulses);
        end
        drv_rd = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_abort();
        do_reset();
        drv_lba = {32'h0000_00E1, 32'h0000_00E0};
        drv_rd  = 2'b01;
        tick();
        n_cmp++;
        if ({sd_rd, owner} !== {1'b1, 2'd0}) begin
            n_err++;
            $display("FAIL abort_grant: rd=%0b owner=%0d, expected rd=1 owner=0", sd_rd, owner);
        end
        drv_rd = 2'b00;
        tick();
        n_cmp++;
        if ({sd_rd, sd_wr, busy, drv_ack} !== 5'b0) begin
            n_err++;
            $display("FAIL abort_drop: rd=%0b wr=%0b busy=%0b ack=%b, expected all zero", sd_rd, sd_wr, busy, drv_ack);
        end
        drv_rd = 2'b11;
        tick();
        n_cmp++;
        if ({sd_rd, owner} !== {1'b1, 2'd0}) begin
            n_err++;
            $display("FAIL abort_last_owner: rd=%0b owner=%0d, expected rd=1 owner=0", sd_rd, owner);
        end
        drv_rd = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_xfer();
        do_reset();
        drv_lba = {32'h0000_0BBB, 32'h0000_0AAA};
        drv_rd  = 2'b01;
        tick();
        sd_ack = 1'b1;
        tick();
        drv_rd     = 2'b11;
        sd_buff_wr = 1'b1;
        #1;
        n_cmp++;
        if (drv_ack !== 2'b01) begin
            n_err++;
            $display("FAIL pre_reset_xfer: ack=%b, expected 01", drv_ack);
        end
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, sd_rd, sd_wr, owner, sd_lba, sd_blk_cnt, drv_ack, drv_buff_wr, tmo_err, sd_buff_din} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_xfer: busy=%0b ack=%b bwr=%b lba=%h din=%h, expected all zero",
                     busy, drv_ack, drv_buff_wr, sd_lba, sd_buff_din);
        end
        drv_rd     = 2'b10;
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if ({sd_rd, owner, sd_lba} !== {1'b1, 2'd1, 32'h0000_0BBB}) begin
            n_err++;
            $display("FAIL post_reset_grant: rd=%0b owner=%0d lba=%h, expected rd=1 owner=1 lba=00000bbb",
                     sd_rd, owner, sd_lba);
        end
        drv_rd = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_random();
        int          lat;
        int          exp_owner;
        int          c;
        int          pick;
        bit          exp_wr;
        logic [31:0] exp_lba;
        logic [5:0]  exp_blk;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            for (int d = 0; d < 2; d++) begin
                if (!(drv_rd[d] || drv_wr[d])) begin
                    drv_rd[d] = 1'($urandom_range(1, 0));
                    drv_wr[d] = ($urandom_range(3, 0) == 0);
                end
            end
            if ((drv_rd | drv_wr) == 2'b00) begin
                pick         = int'($urandom_range(1, 0));
                drv_rd[pick] = 1'b1;
            end
            drv_lba     = {$urandom, $urandom};
            drv_blk_cnt = 12'($urandom);
            exp_owner = -1;
            for (int k = 0; k < 2; k++) begin
                c = (model_last + 1 + k) % 2;
                if (exp_owner < 0 && (drv_rd[c] || drv_wr[c])) exp_owner = c;
            end
            exp_wr  = drv_wr[exp_owner];
            exp_lba = drv_lba[exp_owner*32 +: 32];
            exp_blk = drv_blk_cnt[exp_owner*6 +: 6];
            if ($urandom_range(4, 0) == 0) begin
                tick();
                n_cmp++;
                if ({owner, sd_wr, sd_rd, sd_lba} !== {2'(exp_owner), exp_wr, !exp_wr, exp_lba}) begin
                    n_err++;
                    $display("FAIL rand_abort_grant: it %0d owner=%0d wr=%0b lba=%h, expected owner=%0d wr=%0b lba=%h",
                             it, owner, sd_wr, sd_lba, exp_owner, exp_wr, exp_lba);
                end
                drv_rd[exp_owner] = 1'b0;
                drv_wr[exp_owner] = 1'b0;
                tick();
            end else begin
                do_transfer(exp_owner, exp_wr, exp_lba, exp_blk, int'($urandom_range(3, 0)),
                            int'($urandom_range(6, 1)), lat);
                n_cmp++;
                if (lat !== 1) begin
                    n_err++;
                    $display("FAIL rand_latency: it %0d strobe after %0d cycles, expected 1", it, lat);
                end
                drv_rd[exp_owner] = 1'b0;
                drv_wr[exp_owner] = 1'b0;
                model_last        = exp_owner;
                tick();
            end
            n_cmp++;
            if ({busy, sd_rd, sd_wr, drv_ack} !== 5'b0) begin
                n_err++;
                $display("FAIL rand_idle: it %0d busy=%0b rd=%0b wr=%0b ack=%b, expected all zero",
                         it, busy, sd_rd, sd_wr, drv_ack);
            end
        end
        drv_rd = 2'b00;
        drv_wr = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        model_last   = 1;
        reset_n      = 1'b0;
        drv_rd       = '0;
        drv_wr       = '0;
        sd_ack       = 1'b0;
        sd_buff_wr   = 1'b0;
        drv_lba      = '0;
        drv_blk_cnt  = '0;
        drv_buff_din = '0;
        test_reset();
        test_basic_read();
        test_round_robin();
        test_write_priority();
        test_timeout();
        test_abort();
        test_reset_mid_xfer();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
